// File: rtl/multicycle_main_control.sv
// Main control FSM for the multi-cycle MIPS datapath.
// Steps each instruction through fetch, decode, execute, memory and writeback,
// stalls on the memory ready handshake and aborts a wait that runs too long.
// The addi path is compiled in only when MULTICYCLE_ADDI_EN is defined;
// without it, opcode 001000 is reported as illegal.
module multicycle_main_control #(
   parameter int TIMEOUT = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [5:0] opcode,
   input  logic       mem_ready,
   output logic       pc_write,
   output logic       pc_write_cond,
   output logic       i_or_d,
   output logic       mem_read,
   output logic       mem_write,
   output logic       ir_write,
   output logic       mem_to_reg,
   output logic       reg_dst,
   output logic       reg_write,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] alu_op,
   output logic [1:0] pc_source,
   output logic       illegal_op,
   output logic       mem_timeout,
   output logic [3:0] state_out
);

   typedef enum logic [3:0] {
      IDLE      = 4'd0,
      FETCH     = 4'd1,
      DECODE    = 4'd2,
      MEM_ADDR  = 4'd3,
      MEM_READ  = 4'd4,
      MEM_WB    = 4'd5,
      MEM_WRITE = 4'd6,
      EXECUTE   = 4'd7,
      R_WB      = 4'd8,
      BRANCH    = 4'd9,
      JUMP      = 4'd10,
      ADDI_EX   = 4'd11,
      ADDI_WB   = 4'd12
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_ADDI  = 6'b001000;

   // Counter must be able to hold TIMEOUT itself.
   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

   state_t         state;
   state_t         next_state;
   logic [CW-1:0]  wait_count;
   logic           waiting;
   logic           timed_out;

   // A memory state is stalled when mem_ready is low; an expired stall aborts.
   always_comb begin
      waiting   = ((state == FETCH) || (state == MEM_READ) || (state == MEM_WRITE)) && !mem_ready;
      timed_out = (TIMEOUT != 0) && waiting && (wait_count == CW'(TIMEOUT));
   end

   // State register; reset abandons any instruction in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Stall counter counts consecutive waiting cycles and restarts on every state change.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wait_count <= '0;
      end else if (next_state != state) begin
         wait_count <= '0;
      end else if (waiting) begin
         wait_count <= wait_count + 1'b1;
      end
   end

   // Next-state and Moore control decode; only the fetch loads follow mem_ready directly.
   always_comb begin
      next_state    = state;
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      i_or_d        = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      mem_to_reg    = 1'b0;
      reg_dst       = 1'b0;
      reg_write     = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = 2'b00;
      alu_op        = 2'b00;
      pc_source     = 2'b00;
      illegal_op    = 1'b0;
      mem_timeout   = timed_out;
      case (state)
         IDLE: begin
            next_state = FETCH;
         end
         FETCH: begin
            mem_read  = 1'b1;
            alu_src_b = 2'b01;
            ir_write  = mem_ready;
            pc_write  = mem_ready;
            if (mem_ready)      next_state = DECODE;
            else if (timed_out) next_state = IDLE;
         end
         DECODE: begin
            alu_src_b = 2'b11;
            case (opcode)
               OP_RTYPE:     next_state = EXECUTE;
               OP_LW, OP_SW: next_state = MEM_ADDR;
               OP_BEQ:       next_state = BRANCH;
               OP_J:         next_state = JUMP;
`ifdef MULTICYCLE_ADDI_EN
               OP_ADDI:      next_state = ADDI_EX;
`endif
               default: begin
                  next_state = FETCH;
                  illegal_op = 1'b1;
               end
            endcase
         end
         MEM_ADDR: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            if (opcode == OP_LW)      next_state = MEM_READ;
            else if (opcode == OP_SW) next_state = MEM_WRITE;
            else                      next_state = FETCH;
         end
         MEM_READ: begin
            mem_read = 1'b1;
            i_or_d   = 1'b1;
            if (mem_ready)      next_state = MEM_WB;
            else if (timed_out) next_state = IDLE;
         end
         MEM_WB: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
            next_state = FETCH;
         end
         MEM_WRITE: begin
            mem_write = !timed_out;
            i_or_d    = 1'b1;
            if (mem_ready)      next_state = FETCH;
            else if (timed_out) next_state = IDLE;
         end
         EXECUTE: begin
            alu_src_a  = 1'b1;
            alu_op     = 2'b10;
            next_state = R_WB;
         end
         R_WB: begin
            reg_write  = 1'b1;
            reg_dst    = 1'b1;
            next_state = FETCH;
         end
         BRANCH: begin
            alu_src_a     = 1'b1;
            alu_op        = 2'b01;
            pc_write_cond = 1'b1;
            pc_source     = 2'b01;
            next_state    = FETCH;
         end
         JUMP: begin
            pc_write   = 1'b1;
            pc_source  = 2'b10;
            next_state = FETCH;
         end
`ifdef MULTICYCLE_ADDI_EN
         ADDI_EX: begin
            alu_src_a  = 1'b1;
            alu_src_b  = 2'b10;
            next_state = ADDI_WB;
         end
         ADDI_WB: begin
            reg_write  = 1'b1;
            next_state = FETCH;
         end
`endif
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   assign state_out = state;

endmodule

// File: tb/tb_multicycle_main_control.sv
// Testbench for multicycle_main_control: random instruction stream with random
// memory stalls and occasional timeouts, checked against a per-instruction model.
module tb_multicycle_main_control;

   localparam int TO = 16;

`ifdef MULTICYCLE_ADDI_EN
   localparam bit ADDI_ON = 1'b1;
`else
   localparam bit ADDI_ON = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [5:0] opcode = 6'd0;
   logic       mem_ready = 1'b0;
   logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
   logic       mem_to_reg, reg_dst, reg_write, alu_src_a;
   logic [1:0] alu_src_b, alu_op, pc_source;
   logic       illegal_op, mem_timeout;
   logic [3:0] state_out;
   logic [18:0] outVec;

   int checks = 0;
   int passes = 0;

   multicycle_main_control #(.TIMEOUT(TO)) dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
      .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
      .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
      .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
      .pc_source(pc_source), .illegal_op(illegal_op), .mem_timeout(mem_timeout),
      .state_out(state_out)
   );

   always #5 clk = ~clk;

   assign outVec = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                    mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
                    pc_source, illegal_op, mem_timeout};

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs === exp) passes++;
      else $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
   endtask

   function automatic bit isLegal(input logic [5:0] op);
      return (op == 6'b000000) || (op == 6'b100011) || (op == 6'b101011) ||
             (op == 6'b000100) || (op == 6'b000010) || (ADDI_ON && op == 6'b001000);
   endfunction

   // Expected control word for a given state, taken from the per-state output table.
   function automatic logic [18:0] expVec(input int st, input bit mr, input logic [5:0] op, input bit tmo);
      logic pw, pwc, iod, mrd, mw, irw, m2r, rd, rw, asa, ill;
      logic [1:0] asb, aop, psrc;
      {pw, pwc, iod, mrd, mw, irw, m2r, rd, rw, asa, ill} = '0;
      asb = 2'd0; aop = 2'd0; psrc = 2'd0;
      case (st)
         1:  begin mrd = 1; asb = 2'd1; irw = mr; pw = mr; end
         2:  begin asb = 2'd3; ill = !isLegal(op); end
         3:  begin asa = 1; asb = 2'd2; end
         4:  begin mrd = 1; iod = 1; end
         5:  begin rw = 1; m2r = 1; end
         6:  begin mw = !tmo; iod = 1; end
         7:  begin asa = 1; aop = 2'd2; end
         8:  begin rw = 1; rd = 1; end
         9:  begin asa = 1; aop = 2'd1; pwc = 1; psrc = 2'd1; end
         10: begin pw = 1; psrc = 2'd2; end
         11: begin asa = 1; asb = 2'd2; end
         12: begin rw = 1; end
         default: ;
      endcase
      return {pw, pwc, iod, mrd, mw, irw, m2r, rd, rw, asa, asb, aop, psrc, ill, tmo};
   endfunction

   // One clock cycle: drive mem_ready, check the current state and outputs, advance.
   task automatic applyStimulus(input int st, input bit mr, input bit tmo);
      mem_ready = mr;
      #1;
      checkOutput("state", {28'd0, state_out}, st);
      checkOutput($sformatf("outs_s%0d", st), {13'd0, outVec}, {13'd0, expVec(st, mr, opcode, tmo)});
      @(negedge clk);
   endtask

   // A memory wait state: stalls cycles of mem_ready=0 then completion, or -1 for an abort.
   task automatic runWait(input int st, input int stalls, output bit aborted);
      aborted = 1'b0;
      if (stalls < 0) begin
         for (int i = 0; i <= TO; i++) applyStimulus(st, 1'b0, i == TO);
         aborted = 1'b1;
         opcode = 6'($urandom);
         applyStimulus(0, 1'($urandom), 1'b0);
      end else begin
         for (int i = 0; i < stalls; i++) applyStimulus(st, 1'b0, 1'b0);
         applyStimulus(st, 1'b1, 1'b0);
      end
   endtask

   function automatic int pickStalls();
      int r;
      r = $urandom_range(0, 9);
      if (r == 9) return -1;
      if (r < 5) return 0;
      return r - 4;
   endfunction

   // One instruction starting at FETCH, following the state path its opcode implies.
   task automatic runInstr(input int kind);
      bit ab;
      logic [5:0] op;
      case (kind)
         0: op = 6'b000000;
         1: op = 6'b100011;
         2: op = 6'b101011;
         3: op = 6'b000100;
         4: op = 6'b000010;
         5: op = 6'b001000;
         default: begin
            op = 6'($urandom);
            while (op inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b001000})
               op = 6'($urandom);
         end
      endcase
      opcode = 6'($urandom);
      runWait(1, pickStalls(), ab);
      if (ab) return;
      opcode = op;
      applyStimulus(2, 1'($urandom), 1'b0);
      case (kind)
         0: begin
            opcode = 6'($urandom); applyStimulus(7, 1'($urandom), 1'b0);
            opcode = 6'($urandom); applyStimulus(8, 1'($urandom), 1'b0);
         end
         1: begin
            applyStimulus(3, 1'($urandom), 1'b0);
            opcode = 6'($urandom);
            runWait(4, pickStalls(), ab);
            if (!ab) applyStimulus(5, 1'($urandom), 1'b0);
         end
         2: begin
            applyStimulus(3, 1'($urandom), 1'b0);
            opcode = 6'($urandom);
            runWait(6, pickStalls(), ab);
         end
         3: begin opcode = 6'($urandom); applyStimulus(9, 1'($urandom), 1'b0); end
         4: begin opcode = 6'($urandom); applyStimulus(10, 1'($urandom), 1'b0); end
         5: begin
            if (ADDI_ON) begin
               opcode = 6'($urandom); applyStimulus(11, 1'($urandom), 1'b0);
               opcode = 6'($urandom); applyStimulus(12, 1'($urandom), 1'b0);
            end
         end
         default: ;
      endcase
   endtask

   initial begin
      bit ab;
      rst_n = 1'b0;
      mem_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      #1;
      checkOutput("reset_state", {28'd0, state_out}, 32'd0);
      checkOutput("reset_outs", {13'd0, outVec}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      applyStimulus(0, 1'b1, 1'b0);

      // Guaranteed fetch timeout, then one of every instruction kind.
      runWait(1, -1, ab);
      for (int k = 0; k <= 6; k++) runInstr(k);
      for (int n = 0; n < 80; n++) runInstr($urandom_range(0, 6));

      // Reset asserted while a store is stalled.
      opcode = 6'($urandom);
      runWait(1, 0, ab);
      opcode = 6'b101011;
      applyStimulus(2, 1'b1, 1'b0);
      applyStimulus(3, 1'b1, 1'b0);
      mem_ready = 1'b0;
      #1;
      checkOutput("sw_state", {28'd0, state_out}, 32'd6);
      checkOutput("sw_mem_write", {31'd0, mem_write}, 32'd1);
      #2;
      mem_ready = 1'b1;
      rst_n = 1'b0;
      #1;
      checkOutput("midreset_state", {28'd0, state_out}, 32'd0);
      checkOutput("midreset_outs", {13'd0, outVec}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      applyStimulus(0, 1'b1, 1'b0);
      applyStimulus(1, 1'b1, 1'b0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
